gnrl_vr_fifo: RTL and testbench

Synchronous valid/ready FIFO used as the general-purpose buffering stage throughout the GPGPU front-end and memory paths. Its output data bus feeds the simulation X-checker directly. The output is therefore masked so that no uninitialised storage ever reaches o_dat, whether or not o_vld is asserted. One clock domain; no width conversion.

---
 rtl/gnrl_vr_fifo.sv | 94 +++++++++
 tb/tb_gnrl_vr_fifo.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnrl_vr_fifo.sv
// General-purpose valid/ready FIFO with 1-cycle fall-through and a zero-masked output bus.
// Depth need not be a power of two; pointers wrap by explicit compare against DP-1.
module gnrl_vr_fifo #(
    parameter int unsigned DW        = 32,
    parameter int unsigned DP        = 4,
    parameter bit          CUT_READY = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_vld,
    output logic                       i_rdy,
    input  logic [DW-1:0]              i_dat,
    output logic                       o_vld,
    input  logic                       o_rdy,
    output logic [DW-1:0]              o_dat,
    output logic [$clog2(DP+1)-1:0]    count
);

    localparam int unsigned CW = $clog2(DP + 1);
    localparam int unsigned PW = $clog2(DP);

    localparam logic [CW-1:0] CNT_FULL = CW'(DP);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DP - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   PTR_LIM  = (PW + 1)'(DP);

    logic [DW-1:0] mem [DP];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push;
    logic          pop;
    logic          not_full;

    assign not_full = (count != CNT_FULL);
    assign o_vld    = (count != '0);
    assign push     = i_vld & i_rdy;
    assign pop      = o_vld & o_rdy;

    always_comb begin
        i_rdy = not_full;
        if (!CUT_READY) begin
            i_rdy = not_full | o_rdy;
        end
    end

    // Masked so uninitialised storage never appears on the bus, valid or not.
    always_comb begin
        o_dat = '0;
        if (o_vld) begin
            o_dat = mem[rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
        end else if (push) begin
            wptr <= (wptr == PTR_LAST) ? '0 : wptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr <= '0;
        end else if (pop) begin
            rptr <= (rptr == PTR_LAST) ? '0 : rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    a_count_range: assert property (@(posedge clk) disable iff (reset) count <= CNT_FULL);
    a_wptr_range:  assert property (@(posedge clk) disable iff (reset) {1'b0, wptr} < PTR_LIM);
    a_rptr_range:  assert property (@(posedge clk) disable iff (reset) {1'b0, rptr} < PTR_LIM);
    a_odat_known:  assert property (@(posedge clk) disable iff (reset) !$isunknown(o_dat));

endmodule

// File: tb/tb_gnrl_vr_fifo.sv
// Bench for gnrl_vr_fifo: three instances (DP=4 cut, DP=4 uncut, DP=3 cut) on shared inputs,
// each compared against a queue-based model of occupancy and ordering.
module tb_gnrl_vr_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_vld = 1'b0;
    logic        o_rdy = 1'b0;
    logic [31:0] i_dat = '0;

    logic        rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c;
    logic [31:0] dat_a, dat_b, dat_c;
    logic [2:0]  cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    always #5 clk = ~clk;

    gnrl_vr_fifo #(.DW(32), .DP(4), .CUT_READY(1'b1)) u_a (
        .clk(clk), .reset(reset), .i_vld(i_vld), .i_rdy(rdy_a), .i_dat(i_dat),
        .o_vld(vld_a), .o_rdy(o_rdy), .o_dat(dat_a), .count(cnt_a));

    gnrl_vr_fifo #(.DW(32), .DP(4), .CUT_READY(1'b0)) u_b (
        .clk(clk), .reset(reset), .i_vld(i_vld), .i_rdy(rdy_b), .i_dat(i_dat),
        .o_vld(vld_b), .o_rdy(o_rdy), .o_dat(dat_b), .count(cnt_b));

    gnrl_vr_fifo #(.DW(32), .DP(3), .CUT_READY(1'b1)) u_c (
        .clk(clk), .reset(reset), .i_vld(i_vld), .i_rdy(rdy_c), .i_dat(i_dat),
        .o_vld(vld_c), .o_rdy(o_rdy), .o_dat(dat_c), .count(cnt_c));

    function automatic int dp_of(input int i);
        return (i == 2) ? 3 : 4;
    endfunction

    function automatic bit cut_of(input int i);
        return (i != 1);
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [31:0] qhead(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpush(input int i, input logic [31:0] d);
        case (i)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic qpop(input int i);
        logic [31:0] d;
        case (i)
            0:       d = q0.pop_front();
            1:       d = q1.pop_front();
            default: d = q2.pop_front();
        endcase
    endtask

    task automatic qclear();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Expected {i_rdy, o_vld, count, o_dat} for instance i given the current o_rdy.
    function automatic logic [37:0] expv(input int i);
        int          sz;
        logic [31:0] d;
        logic        r;
        sz = qsize(i);
        d  = (sz > 0) ? qhead(i) : 32'h0;
        r  = (sz < dp_of(i)) || (!cut_of(i) && o_rdy);
        return {r, (sz > 0), 4'(sz), d};
    endfunction

    function automatic logic [37:0] obs(input int i);
        case (i)
            0:       return {rdy_a, vld_a, 4'(cnt_a), dat_a};
            1:       return {rdy_b, vld_b, 4'(cnt_b), dat_b};
            default: return {rdy_c, vld_c, 4'(cnt_c), dat_c};
        endcase
    endfunction

    task automatic drive(input logic v, input logic r, input logic [31:0] d);
        i_vld = v;
        o_rdy = r;
        i_dat = d;
        #1;
    endtask

    // Advances one clock; the model decides push/pop from the inputs held before the edge.
    task automatic tick();
        bit pu[3];
        bit po[3];
        for (int i = 0; i < 3; i++) begin
            pu[i] = i_vld && ((qsize(i) < dp_of(i)) || (!cut_of(i) && o_rdy));
            po[i] = (qsize(i) > 0) && o_rdy;
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (po[i]) qpop(i);
            if (pu[i]) qpush(i, i_dat);
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 32'h0);
        #12;
        reset = 1'b0;
        qclear();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs(i) !== expv(i)) begin
                n_fail++;
                $display("FAIL reset_idle dut%0d got %h exp %h", i, obs(i), expv(i));
            end
        end
        drive(1'b1, 1'b0, 32'h0000_0011);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0022);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        qclear();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs(i) !== {1'b1, 1'b0, 4'd0, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_async dut%0d got %h exp %h", i, obs(i), {1'b1, 1'b0, 4'd0, 32'h0});
            end
        end
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_fill_drain();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'hA0 + 32'(k));
            tick();
            drive(1'b0, 1'b0, 32'h0);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL fill dut%0d step%0d got %h exp %h", i, k, obs(i), expv(i));
                end
            end
        end
        n_checks++;
        if (cnt_a !== 3'd4 || rdy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full dut0 got cnt=%0d rdy=%b exp cnt=4 rdy=0", cnt_a, rdy_a);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 32'h0);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL drain dut%0d step%0d got %h exp %h", i, k, obs(i), expv(i));
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        for (int k = 1; k <= 12; k++) begin
            drive(k <= 10, 1'b1, 32'(k));
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL wrap dut%0d step%0d got %h exp %h", i, k, obs(i), expv(i));
                end
            end
            if (k >= 2 && k <= 10) begin
                n_checks++;
                if (cnt_c !== 2'd1 || dat_c !== 32'(k - 1)) begin
                    n_fail++;
                    $display("FAIL wrap_dp3 step%0d got cnt=%0d dat=%h exp cnt=1 dat=%h",
                             k, cnt_c, dat_c, 32'(k - 1));
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_full_pushpop();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'hC0 + 32'(k));
            tick();
        end
        drive(1'b1, 1'b1, 32'hBEEF);
        n_checks++;
        if (rdy_a !== 1'b0 || rdy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL full_rdy got a=%b b=%b exp a=0 b=1", rdy_a, rdy_b);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (cnt_a !== 3'd3 || cnt_b !== 3'd4) begin
            n_fail++;
            $display("FAIL full_cnt got a=%0d b=%0d exp a=3 b=4", cnt_a, cnt_b);
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, 32'h0);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL full_drain dut%0d step%0d got %h exp %h", i, k, obs(i), expv(i));
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 32'h5151);
        tick();
        drive(1'b1, 1'b0, 32'h5252);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 32'hFFFF_FFFF);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL stall dut%0d step%0d got %h exp %h", i, k, obs(i), expv(i));
                end
            end
            n_checks++;
            if (dat_b !== 32'h5151 || cnt_b !== 3'd2) begin
                n_fail++;
                $display("FAIL stall_hold step%0d got dat=%h cnt=%0d exp dat=5151 cnt=2", k, dat_b, cnt_b);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h70 + 32'(k));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        qclear();
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h55);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs(i) !== expv(i)) begin
                n_fail++;
                $display("FAIL mid_reset dut%0d got %h exp %h", i, obs(i), expv(i));
            end
        end
        n_checks++;
        if (dat_a !== 32'h55 || cnt_a !== 3'd1 || dat_c !== 32'h55) begin
            n_fail++;
            $display("FAIL mid_reset_head got a=%h/%0d c=%h exp 55/1 55", dat_a, cnt_a, dat_c);
        end
        drive(1'b0, 1'b1, 32'h0);
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45), $urandom);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d got %h exp %h", i, k, obs(i), expv(i));
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_pushpop();
        test_stall();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
